regfile_sb: RTL

Parametrised multi-port register file with an integrated scoreboard, succeeding the fixed 8x16 register bank.
- Two combinational read ports, one synchronous write port.
- Per-register busy bits reserved by the issue stage and cleared by writeback.
- Sits between decode/issue (read and reserve) and writeback (write).
- Provides hazard flags and a busy count for stall logic.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard.sv | 63 ++++++
 rtl/regfile_sb.sv | 77 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and index/word typedefs for the regfile_sb register file.
package regfile_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned DEPTH_DEF = 8;
    localparam int unsigned AW_DEF    = $clog2(DEPTH_DEF);

    typedef logic [AW_DEF-1:0]    reg_idx_t;
    typedef logic [WIDTH_DEF-1:0] reg_word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue reserves a register, writeback clears it.
// Tracks the number of busy registers for stall logic.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] c_index,
    input  logic                     rsv_en,
    input  logic [$clog2(DEPTH)-1:0] rsv_index,
    input  logic [$clog2(DEPTH)-1:0] a_index,
    input  logic [$clog2(DEPTH)-1:0] b_index,
    output logic                     a_busy,
    output logic                     b_busy,
    output logic                     rsv_ok,
    output logic [$clog2(DEPTH):0]   busy_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW:0]      count_q, count_d;
    logic             clear_hit;

    // Reservation grant, busy vector and count next-state.
    always_comb begin
        rsv_ok    = rsv_en & ~busy_q[rsv_index];
        clear_hit = we & busy_q[c_index];
        busy_d    = busy_q;
        if (we) begin
            busy_d[c_index] = 1'b0;
        end
        // Reservation is applied last so it wins over a same-index clear.
        if (rsv_ok) begin
            busy_d[rsv_index] = 1'b1;
        end
        count_d = count_q;
        if (rsv_ok && !clear_hit) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!rsv_ok && clear_hit) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    // Scoreboard state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign a_busy     = busy_q[a_index];
    assign b_busy     = busy_q[b_index];
    assign busy_count = count_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one synchronous write
// port and an integrated busy-bit scoreboard.
// Optional build macro REGFILE_SB_BYPASS_EN enables write-through forwarding
// to the read ports and masks the read-port busy flags on a forwarded hit.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(DEPTH)-1:0] a_index,
    input  logic [$clog2(DEPTH)-1:0] b_index,
    output logic [WIDTH-1:0]         a_output,
    output logic [WIDTH-1:0]         b_output,
    output logic                     a_busy,
    output logic                     b_busy,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] c_index,
    input  logic [WIDTH-1:0]         d_input,
    input  logic                     rsv_en,
    input  logic [$clog2(DEPTH)-1:0] rsv_index,
    output logic                     rsv_ok,
    output logic [$clog2(DEPTH):0]   busy_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             a_busy_raw, b_busy_raw;

    // Data storage: clear on reset, otherwise single write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[c_index] <= d_input;
        end
    end

    // Read muxes, with optional same-cycle forwarding of the write data.
    always_comb begin
        a_output = mem_q[a_index];
        b_output = mem_q[b_index];
        a_busy   = a_busy_raw;
        b_busy   = b_busy_raw;
`ifdef REGFILE_SB_BYPASS_EN
        if (we && (c_index == a_index)) begin
            a_output = d_input;
            a_busy   = 1'b0;
        end
        if (we && (c_index == b_index)) begin
            b_output = d_input;
            b_busy   = 1'b0;
        end
`endif
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .c_index    (c_index),
        .rsv_en     (rsv_en),
        .rsv_index  (rsv_index),
        .a_index    (a_index),
        .b_index    (b_index),
        .a_busy     (a_busy_raw),
        .b_busy     (b_busy_raw),
        .rsv_ok     (rsv_ok),
        .busy_count (busy_count)
    );

endmodule
